// File: rtl/core_dump_ctrl.sv
// End-of-program dump controller.
// Detects a halted core from the fetch-stage instruction: one instruction held
// too long, or a run of repeated NOPs. It then reads data memory from
// START_ADDR to END_ADDR through the debug port and streams each word as
// four bytes, low byte first, on a valid/ready byte stream. It also keeps a
// running 32-bit sum of every word dumped.
module core_dump_ctrl #(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned START_ADDR  = 0,
    parameter int unsigned END_ADDR    = 35,
    parameter int unsigned READ_LAT    = 1,
    parameter int unsigned STALL_LIMIT = 49,
    parameter int unsigned NOP_LIMIT   = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [31:0]       inst_in,
    input  logic              start,
    output logic [ADDR_W-1:0] con_addr,
    input  logic [31:0]       con_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              halted,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);

    // The counters only need to reach their limit, because they saturate there.
    localparam int unsigned SAME_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam int unsigned NOP_W  = (NOP_LIMIT < 1) ? 1 : $clog2(NOP_LIMIT + 1);
    localparam int unsigned WAIT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state;
    logic [31:0]       last_inst;
    logic [SAME_W-1:0] same_cnt;
    logic [NOP_W-1:0]  nop_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        byte_idx;
    logic [23:0]       word_hi;
    logic              is_nop;
    logic              halt_hit;

    // Halt signature: the 32-bit addi-x0 NOP, or the compressed c.nop in the low half
    assign is_nop = (inst_in[15:0] == 16'h0001) || (inst_in == 32'h0000_0013);

    // A limit reached while idle and not yet halted starts the dump on this edge
    assign halt_hit = (state == S_IDLE) && !halted &&
                      ((same_cnt == SAME_W'(STALL_LIMIT)) || (nop_cnt == NOP_W'(NOP_LIMIT)));

    // Halt detector: count repeated instructions and set the sticky halt flag
    always_ff @(posedge clk) begin
        if (!nrst) begin
            last_inst <= 32'd0;
            same_cnt  <= '0;
            nop_cnt   <= '0;
            halted    <= 1'b0;
        end else if ((state == S_IDLE) && !halted) begin
            if (halt_hit) begin
                halted <= 1'b1;
            end
            if (inst_in == last_inst) begin
                if (same_cnt != SAME_W'(STALL_LIMIT)) begin
                    same_cnt <= same_cnt + SAME_W'(1);
                end
                if (is_nop && (nop_cnt != NOP_W'(NOP_LIMIT))) begin
                    nop_cnt <= nop_cnt + NOP_W'(1);
                end
            end else begin
                last_inst <= inst_in;
                same_cnt  <= '0;
                nop_cnt   <= '0;
            end
        end
    end

    // Dump sequencer: address, wait out the read latency, capture, then send 4 bytes
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= S_IDLE;
            con_addr <= ADDR_W'(START_ADDR);
            wait_cnt <= '0;
            byte_idx <= 2'd0;
            word_hi  <= 24'd0;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            checksum <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start || halt_hit) begin
                        state    <= S_ADDR;
                        busy     <= 1'b1;
                        con_addr <= ADDR_W'(START_ADDR);
                    end
                end

                // con_addr is stable here; ADDR, the wait cycles and LOAD together span READ_LAT+1 cycles
                S_ADDR: begin
                    wait_cnt <= WAIT_W'(READ_LAT - 1);
                    state    <= (READ_LAT <= 1) ? S_LOAD : S_WAIT;
                end

                S_WAIT: begin
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                    if (wait_cnt <= WAIT_W'(1)) begin
                        state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    word_hi  <= con_out[31:8];
                    checksum <= checksum + con_out;
                    byte_idx <= 2'd0;
                    tx_data  <= con_out[7:0];
                    tx_valid <= 1'b1;
                    state    <= S_SEND;
                end

                // Advance only on a handshake, so the byte holds steady under backpressure
                S_SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (byte_idx == 2'd3) begin
                            tx_valid <= 1'b0;
                            if (con_addr == ADDR_W'(END_ADDR)) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                con_addr <= con_addr + ADDR_W'(1);
                                state    <= S_ADDR;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            case (byte_idx)
                                2'd0:    tx_data <= word_hi[7:0];
                                2'd1:    tx_data <= word_hi[15:8];
                                default: tx_data <= word_hi[23:16];
                            endcase
                        end
                    end
                end

                S_DONE: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_dump_ctrl.sv
// Directed bench for core_dump_ctrl.
// dut_a uses the default parameters. dut_b uses READ_LAT=3 with a 3-stage
// memory and dumps addresses 3..5. dut_c dumps the single word at address 9.
module tb_core_dump_ctrl;

    localparam int unsigned ADDR_W = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst, start, start_b, start_c, tx_ready;
    logic [31:0] inst_in, inst_b;
    bit          spin, bp;

    logic [ADDR_W-1:0] con_addr_a, con_addr_b, con_addr_c;
    logic [31:0]       con_out_a, con_out_b, con_out_c;
    logic [7:0]        tx_data_a, tx_data_b, tx_data_c;
    logic              tx_valid_a, tx_valid_b, tx_valid_c;
    logic              halted_a, halted_b, halted_c;
    logic              busy_a, busy_b, busy_c;
    logic              done_a, done_b, done_c;
    logic [31:0]       checksum_a, checksum_b, checksum_c;
    logic [31:0]       pipe1_b, pipe2_b;

    core_dump_ctrl dut_a (
        .clk(clk), .nrst(nrst), .inst_in(inst_in), .start(start),
        .con_addr(con_addr_a), .con_out(con_out_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
        .halted(halted_a), .busy(busy_a), .done(done_a), .checksum(checksum_a)
    );

    core_dump_ctrl #(.START_ADDR(3), .END_ADDR(5), .READ_LAT(3)) dut_b (
        .clk(clk), .nrst(nrst), .inst_in(inst_b), .start(start_b),
        .con_addr(con_addr_b), .con_out(con_out_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
        .halted(halted_b), .busy(busy_b), .done(done_b), .checksum(checksum_b)
    );

    core_dump_ctrl #(.START_ADDR(9), .END_ADDR(9)) dut_c (
        .clk(clk), .nrst(nrst), .inst_in(inst_b), .start(start_c),
        .con_addr(con_addr_c), .con_out(con_out_c),
        .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready),
        .halted(halted_c), .busy(busy_c), .done(done_c), .checksum(checksum_c)
    );

    // Memory models: word[a] = a*0x01010101 with 1-cycle latency; dut_b sees an offset pattern with 3-cycle latency
    always @(posedge clk) begin
        con_out_a <= 32'(con_addr_a) * 32'h0101_0101;
        con_out_c <= 32'(con_addr_c) * 32'h0101_0101;
        pipe1_b   <= 32'h1122_3344 + 32'(con_addr_b) * 32'h0101_0101;
        pipe2_b   <= pipe1_b;
        con_out_b <= pipe2_b;
    end

    // Byte capture on handshakes, plus a check that stalled bytes hold still
    logic [7:0] q_a[$], q_b[$], q_c[$];
    int         stab_err = 0;
    bit         stall_prev = 1'b0;
    logic [7:0] data_prev = 8'd0;

    always @(negedge clk) begin
        if (nrst) begin
            if (tx_valid_a && tx_ready) q_a.push_back(tx_data_a);
            if (tx_valid_b && tx_ready) q_b.push_back(tx_data_b);
            if (tx_valid_c && tx_ready) q_c.push_back(tx_data_c);
            if (stall_prev && (!tx_valid_a || (tx_data_a != data_prev))) stab_err++;
            stall_prev = tx_valid_a && !tx_ready;
            data_prev  = tx_data_a;
        end else begin
            stall_prev = 1'b0;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; inputs change 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        if (spin) inst_in = inst_in + 32'd1;
        inst_b   = inst_b + 32'd1;
        tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!halted_a && n < 300);
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!done_a && n < limit);
    endtask

    // The dumped byte k of dut_a is the value k/4, since every byte of word[a] equals a
    function automatic int seq_err_a(input int base);
        int e = 0;
        for (int k = 0; k < 144; k++)
            if ((base + k >= q_a.size()) || (q_a[base + k] != 8'(k / 4))) e++;
        return e;
    endfunction

    function automatic logic [15:0] byte_a(input int idx);
        return (idx < q_a.size()) ? 16'(q_a[idx]) : 16'hFFFF;
    endfunction

    function automatic logic [7:0] exp_b(input int k);
        logic [31:0] w;
        w = 32'h1122_3344 + 32'(3 + k / 4) * 32'h0101_0101;
        return w[8 * (k % 4) +: 8];
    endfunction

    initial begin
        int n, t, tb_t, tc_t, base_a, e;
        nrst = 1'b0; start = 1'b0; start_b = 1'b0; start_c = 1'b0;
        inst_in = 32'h1000_0000; inst_b = 32'h2000_0000;
        tx_ready = 1'b1; spin = 1'b0; bp = 1'b0;

        // Reset state
        step();
        step();
        check("rst_con_addr", 64'(con_addr_a), 64'd0);
        check("rst_tx_valid", 64'(tx_valid_a), 64'd0);
        check("rst_tx_data",  64'(tx_data_a),  64'd0);
        check("rst_flags", 64'({halted_a, busy_a, done_a}), 64'd0);
        check("rst_checksum", 64'(checksum_a), 64'd0);
        nrst = 1'b1;

        // Instruction changing every 40 cycles never halts
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < 40; i++) step();
            inst_in = inst_in + 32'h100;
        end
        check("nohalt_halted", 64'(halted_a), 64'd0);
        check("nohalt_busy",   64'(busy_a),   64'd0);

        // Stall halt: 1 load + 49 counts + 1 edge, and the dump starts on that edge
        inst_in = 32'h0000_006F;
        do_reset();
        base_a = q_a.size();
        wait_halt(n);
        check("stall_halt_cycles", 64'(n), 64'd51);
        check("stall_busy", 64'(busy_a), 64'd1);
        wait_done(400, n);
        check("dump_cycles", 64'(n), 64'd216);
        check("dump_bytes", 64'(q_a.size() - base_a), 64'd144);
        check("dump_byte4", 64'(byte_a(base_a + 4)), 64'h01);
        check("dump_byte143", 64'(byte_a(base_a + 143)), 64'h23);
        check("dump_seq_errs", 64'(seq_err_a(base_a)), 64'd0);
        // Sum of a*0x01010101 for a=0..35: every byte column adds 630=0x276, carrying 2 upward
        check("dump_checksum", 64'(checksum_a), 64'h7878_7876);
        check("dump_final_flags", 64'({halted_a, busy_a, done_a, tx_valid_a}), 64'b1010);
        check("dump_last_addr", 64'(con_addr_a), 64'd35);

        // A start pulse in DONE does nothing
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("done_start_flags", 64'({busy_a, done_a}), 64'b01);
        check("done_start_bytes", 64'(q_a.size() - base_a), 64'd144);

        // NOP halt, then a dump under random backpressure
        inst_in = 32'h0000_0013;
        do_reset();
        base_a = q_a.size();
        wait_halt(n);
        check("nop_halt_cycles", 64'(n), 64'd18);
        bp = 1'b1;
        wait_done(3000, n);
        bp = 1'b0;
        check("bp_done", 64'(done_a), 64'd1);
        check("bp_bytes", 64'(q_a.size() - base_a), 64'd144);
        check("bp_seq_errs", 64'(seq_err_a(base_a)), 64'd0);
        check("bp_stable_errs", 64'(stab_err), 64'd0);
        check("bp_checksum", 64'(checksum_a), 64'h7878_7876);

        // Compressed NOP halt, then reset during the third word
        inst_in = 32'hABCD_0001;
        do_reset();
        base_a = q_a.size();
        wait_halt(n);
        check("cnop_halt_cycles", 64'(n), 64'd18);
        n = 0;
        while ((q_a.size() - base_a < 9) && n < 100) begin
            step();
            n++;
        end
        check("mid_bytes_before_rst", 64'(q_a.size() - base_a), 64'd9);
        check("mid_busy_valid", 64'({busy_a, tx_valid_a}), 64'b11);
        nrst = 1'b0;
        spin = 1'b1;
        step();
        check("mid_rst_con_addr", 64'(con_addr_a), 64'd0);
        check("mid_rst_tx", 64'({tx_valid_a, tx_data_a}), 64'd0);
        check("mid_rst_flags", 64'({halted_a, busy_a, done_a}), 64'd0);
        check("mid_rst_checksum", 64'(checksum_a), 64'd0);
        nrst = 1'b1;
        step();
        base_a = q_a.size();
        start = 1'b1;
        step();
        start = 1'b0;
        check("rerun_busy", 64'(busy_a), 64'd1);
        wait_done(400, n);
        check("rerun_cycles", 64'(n), 64'd216);
        check("rerun_bytes", 64'(q_a.size() - base_a), 64'd144);
        check("rerun_seq_errs", 64'(seq_err_a(base_a)), 64'd0);
        check("rerun_checksum", 64'(checksum_a), 64'h7878_7876);
        check("rerun_halted", 64'(halted_a), 64'd0);

        // READ_LAT=3 three-word dump and single-word dump, started together
        start_b = 1'b1;
        start_c = 1'b1;
        step();
        start_b = 1'b0;
        start_c = 1'b0;
        t = 1; tb_t = 0; tc_t = 0;
        while (t < 60) begin
            step();
            t++;
            if (done_b && tb_t == 0) tb_t = t;
            if (done_c && tc_t == 0) tc_t = t;
        end
        check("lat3_done_cycles", 64'(tb_t), 64'd25);
        check("lat3_bytes", 64'(q_b.size()), 64'd12);
        e = 0;
        for (int k = 0; k < 12; k++)
            if ((k >= q_b.size()) || (q_b[k] != exp_b(k))) e++;
        check("lat3_seq_errs", 64'(e), 64'd0);
        check("lat3_first_last", 64'({(q_b.size() > 0) ? q_b[0] : 8'h00,
                                      (q_b.size() > 11) ? q_b[11] : 8'h00}), 64'h4716);
        check("lat3_checksum", 64'(checksum_b), 64'h3F72_A5D8);
        check("lat3_flags", 64'({halted_b, busy_b, done_b}), 64'b001);
        check("one_done_cycles", 64'(tc_t), 64'd7);
        check("one_bytes", 64'(q_c.size()), 64'd4);
        e = 0;
        for (int k = 0; k < 4; k++)
            if ((k >= q_c.size()) || (q_c[k] != 8'h09)) e++;
        check("one_seq_errs", 64'(e), 64'd0);
        check("one_checksum", 64'(checksum_c), 64'h0909_0909);
        check("one_addr", 64'(con_addr_c), 64'd9);
        check("one_flags", 64'({halted_c, busy_c, done_c}), 64'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
